// File: rtl/pixel_stream_packer_pkg.sv
// Sensor configuration shared by the pixel stream packer and its FIFO:
// geometry constants, the captured pixel word and the tagged FIFO entry.
package pixel_stream_packer_pkg;

    localparam int OUTPUT_BUS_WIDTH   = 2;
    localparam int PIXEL_BITS         = 8;
    localparam int PIXEL_ARRAY_WIDTH  = 2;
    localparam int PIXEL_ARRAY_HEIGHT = 2;
    localparam int WORDS_PER_ROW      = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;

    typedef logic [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0] pixel_word_t;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic        eof;
        pixel_word_t data;
    } stream_entry_t;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO of tagged stream entries. A push into a full FIFO
// is accepted when a pop lands in the same cycle. The head is read from
// storage flops only and is forced to zero while the FIFO is empty.
module stream_fifo
    import pixel_stream_packer_pkg::*;
#(
    parameter type entry_t = stream_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic   CLK,
    input  logic   RESET,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int AW = cnt_width(DEPTH);

    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("stream_fifo DEPTH must be a power of two and at least 2");
    end

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until the occupancy covers them.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pixel_stream_packer.sv
// Captures sensor output words on the (resynchronised) sensor output strobe,
// tags them with frame position, queues them and presents them on a
// valid/ready stream. Tracks drops, frame-sync errors and completed frames.
module pixel_stream_packer #(
    parameter int BUS_WIDTH    = pixel_stream_packer_pkg::OUTPUT_BUS_WIDTH,
    parameter int PIXEL_BITS   = pixel_stream_packer_pkg::PIXEL_BITS,
    parameter int ARRAY_WIDTH  = pixel_stream_packer_pkg::PIXEL_ARRAY_WIDTH,
    parameter int ARRAY_HEIGHT = pixel_stream_packer_pkg::PIXEL_ARRAY_HEIGHT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            IN_STROBE,
    input  logic [BUS_WIDTH*PIXEL_BITS-1:0] IN_DATA,
    input  logic                            IN_FRAME_DONE,
    output logic                            OUT_VALID,
    input  logic                            OUT_READY,
    output logic [BUS_WIDTH*PIXEL_BITS-1:0] OUT_DATA,
    output logic                            OUT_SOF,
    output logic                            OUT_EOL,
    output logic                            OUT_EOF,
    output logic                            OVERFLOW,
    output logic                            SYNC_ERROR,
    output logic [15:0]                     FRAME_COUNT
);

    import pixel_stream_packer_pkg::*;

    localparam int WPR = ARRAY_WIDTH / BUS_WIDTH;
    localparam int CW  = cnt_width(WPR);
    localparam int RW  = cnt_width(ARRAY_HEIGHT);

    if ((ARRAY_WIDTH % BUS_WIDTH) != 0) begin : g_bad_width
        $error("ARRAY_WIDTH must be a multiple of BUS_WIDTH");
    end

    // Local mirrors of the package word/entry types so overridden widths work.
    typedef logic [BUS_WIDTH-1:0][PIXEL_BITS-1:0] word_t;
    typedef struct packed {
        logic  sof;
        logic  eol;
        logic  eof;
        word_t data;
    } entry_t;

    // [0],[1]: two-flop synchroniser; [2]: previous synchronised level.
    logic [2:0]    strobe_sync;
    logic [2:0]    fd_sync;
    logic          capture;
    logic          fd_rise;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          row_last;
    logic          at_origin;
    logic          resync;
    entry_t        cap_entry;
    entry_t        head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          xfer;
    logic          overflow_q;
    logic          sync_err_q;
    logic [15:0]   frame_cnt;

    // Synchronise the async sensor strobes and register their rising edges.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            strobe_sync <= '0;
            fd_sync     <= '0;
            capture     <= 1'b0;
            fd_rise     <= 1'b0;
        end else begin
            strobe_sync <= {strobe_sync[1:0], IN_STROBE};
            fd_sync     <= {fd_sync[1:0], IN_FRAME_DONE};
            capture     <= strobe_sync[1] & ~strobe_sync[2];
            fd_rise     <= fd_sync[1] & ~fd_sync[2];
        end
    end

    assign col_last  = (col == CW'(WPR - 1));
    assign row_last  = (row == RW'(ARRAY_HEIGHT - 1));
    assign at_origin = (col == '0) && (row == '0);
    assign resync    = fd_rise && !at_origin;
    assign xfer      = OUT_VALID && OUT_READY;

    // Tags come from the counters as they stand before this cycle's update.
    always_comb begin
        cap_entry      = '0;
        cap_entry.sof  = at_origin;
        cap_entry.eol  = col_last;
        cap_entry.eof  = col_last && row_last;
        cap_entry.data = word_t'(IN_DATA);
    end

    // Frame position; advances on every capture, dropped words included.
    // A mid-frame frame-done wins over a same-cycle capture advance.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            col <= '0;
            row <= '0;
        end else if (resync) begin
            col <= '0;
            row <= '0;
        end else if (capture) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    stream_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (capture),
        .push_data (cap_entry),
        .pop       (xfer),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    // Sticky status flags and the completed-frame counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            overflow_q <= 1'b0;
            sync_err_q <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            if (capture && fifo_full && !xfer) overflow_q <= 1'b1;
            if (resync)                        sync_err_q <= 1'b1;
            frame_cnt <= frame_cnt + 16'(xfer && head.eof);
        end
    end

    assign OUT_VALID   = !fifo_empty;
    assign OUT_DATA    = head.data;
    assign OUT_SOF     = head.sof;
    assign OUT_EOL     = head.eol;
    assign OUT_EOF     = head.eof;
    assign OVERFLOW    = overflow_q;
    assign SYNC_ERROR  = sync_err_q;
    assign FRAME_COUNT = frame_cnt;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Directed bench for pixel_stream_packer on a 2x2 array, 2-pixel bus, depth-4 FIFO.
module tb_pixel_stream_packer;

    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          IN_STROBE;
    logic [DW-1:0] IN_DATA;
    logic          IN_FRAME_DONE;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_SOF;
    logic          OUT_EOL;
    logic          OUT_EOF;
    logic          OVERFLOW;
    logic          SYNC_ERROR;
    logic [15:0]   FRAME_COUNT;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic pre_valid;

    always #5 CLK = ~CLK;

    pixel_stream_packer #(
        .BUS_WIDTH    (2),
        .PIXEL_BITS   (8),
        .ARRAY_WIDTH  (2),
        .ARRAY_HEIGHT (2),
        .FIFO_DEPTH   (4)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .IN_STROBE     (IN_STROBE),
        .IN_DATA       (IN_DATA),
        .IN_FRAME_DONE (IN_FRAME_DONE),
        .OUT_VALID     (OUT_VALID),
        .OUT_READY     (OUT_READY),
        .OUT_DATA      (OUT_DATA),
        .OUT_SOF       (OUT_SOF),
        .OUT_EOL       (OUT_EOL),
        .OUT_EOF       (OUT_EOF),
        .OVERFLOW      (OVERFLOW),
        .SYNC_ERROR    (SYNC_ERROR),
        .FRAME_COUNT   (FRAME_COUNT)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_head(input string name, input logic [DW-1:0] d,
                            input logic sof, input logic eol, input logic eof);
        chk({name, "_valid"}, OUT_VALID, 1);
        chk({name, "_data"}, OUT_DATA, d);
        chk({name, "_sof"}, OUT_SOF, sof);
        chk({name, "_eol"}, OUT_EOL, eol);
        chk({name, "_eof"}, OUT_EOF, eof);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_valid"}, OUT_VALID, 0);
        chk({name, "_data"}, OUT_DATA, 0);
        chk({name, "_tags"}, {OUT_SOF, OUT_EOL, OUT_EOF}, 0);
        chk({name, "_ovf"}, OVERFLOW, 0);
        chk({name, "_serr"}, SYNC_ERROR, 0);
        chk({name, "_fcnt"}, FRAME_COUNT, 0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // One strobe; returns on the negedge after the 4th posedge past the rise,
    // where a word landing in an empty FIFO is first visible. pre_valid
    // collects OUT_VALID over the earlier samples. pop_at_cap raises
    // OUT_READY for exactly the capture edge.
    task automatic send(input logic [DW-1:0] d, input logic pop_at_cap);
        pre_valid = 1'b0;
        @(posedge CLK); #1;
        IN_DATA   = d;
        IN_STROBE = 1'b1;
        @(negedge CLK); pre_valid |= OUT_VALID;
        @(posedge CLK);
        @(negedge CLK); pre_valid |= OUT_VALID;
        @(posedge CLK); #1;
        IN_STROBE = 1'b0;
        @(negedge CLK); pre_valid |= OUT_VALID;
        @(posedge CLK); #1;
        if (pop_at_cap) OUT_READY = 1'b1;
        @(negedge CLK); pre_valid |= OUT_VALID;
        @(posedge CLK); #1;
        if (pop_at_cap) OUT_READY = 1'b0;
        @(negedge CLK);
    endtask

    task automatic pulse_fd();
        @(posedge CLK); #1;
        IN_FRAME_DONE = 1'b1;
        repeat (2) @(posedge CLK);
        #1 IN_FRAME_DONE = 1'b0;
        repeat (2) @(posedge CLK);
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic          fd;
        logic          sof;
        logic          eol;
        logic          eof;
        logic          serr;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w [6];

        // d, frame-done pulse before strobe, sof, eol, eof, SYNC_ERROR after
        tbl[0] = '{16'hA101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{16'hA202, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{16'hB103, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{16'hB204, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{16'hC205, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{16'hD106, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{16'hD207, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        RESET         = 1'b1;
        IN_STROBE     = 1'b0;
        IN_DATA       = '0;
        IN_FRAME_DONE = 1'b0;
        OUT_READY     = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_all_zero("reset");
        RESET = 1'b0;

        // Streaming with OUT_READY=1, including a mid-frame and an aligned frame-done.
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].fd) pulse_fd();
            send(tbl[i].d, 1'b0);
            chk($sformatf("v%0d_early_valid", i), pre_valid, 0);
            chk_head($sformatf("v%0d", i), tbl[i].d, tbl[i].sof, tbl[i].eol, tbl[i].eof);
            chk($sformatf("v%0d_serr", i), SYNC_ERROR, tbl[i].serr);
            if (i == 1) begin
                @(negedge CLK);
                chk("frame1_fcnt", FRAME_COUNT, 1);
            end
        end
        @(negedge CLK);
        chk("stream_fcnt", FRAME_COUNT, 3);
        chk("stream_ovf", OVERFLOW, 0);
        chk("stream_empty", OUT_VALID, 0);

        // Stalled sink: 4 words fill the FIFO, the 5th is dropped.
        do_reset();
        OUT_READY = 1'b0;
        for (int i = 0; i < 6; i++) w[i] = 16'h5000 + 16'(i + 1);
        for (int i = 0; i < 5; i++) begin
            send(w[i], 1'b0);
            chk_head($sformatf("hold%0d", i), w[0], 1'b1, 1'b1, 1'b0);
            if (i == 3) chk("ovf_before_drop", OVERFLOW, 0);
        end
        chk("ovf_after_drop", OVERFLOW, 1);
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk_head($sformatf("drain%0d", i), w[i], (i % 2) == 0, 1'b1, (i % 2) == 1);
        end
        @(negedge CLK);
        chk("drain_empty", OUT_VALID, 0);
        chk("drain_fcnt", FRAME_COUNT, 2);
        // Dropped word still advanced the counters, so this one closes a frame.
        send(w[5], 1'b0);
        chk_head("after_drop", w[5], 1'b0, 1'b1, 1'b1);
        chk("ovf_sticky", OVERFLOW, 1);

        // Full FIFO with a pop on the capture edge: nothing dropped.
        do_reset();
        OUT_READY = 1'b0;
        for (int i = 0; i < 4; i++) send(16'h6001 + 16'(i), 1'b0);
        send(16'h6005, 1'b1);
        chk_head("swap_head", 16'h6002, 1'b0, 1'b1, 1'b1);
        chk("swap_ovf", OVERFLOW, 0);
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk($sformatf("swap_drain%0d_valid", i), OUT_VALID, 1);
            chk($sformatf("swap_drain%0d_data", i), OUT_DATA, 16'h6002 + 16'(i));
        end
        @(negedge CLK);
        chk("swap_empty", OUT_VALID, 0);
        chk("swap_ovf_end", OVERFLOW, 0);

        // Reset with three words queued mid-frame.
        do_reset();
        OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) send(16'h7001 + 16'(i), 1'b0);
        chk_head("pre_rst", 16'h7001, 1'b1, 1'b1, 1'b0);
        @(posedge CLK); #2;
        RESET = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        @(negedge CLK);
        RESET     = 1'b0;
        OUT_READY = 1'b1;
        send(16'h7004, 1'b0);
        chk("post_rst_early_valid", pre_valid, 0);
        chk_head("post_rst", 16'h7004, 1'b1, 1'b1, 1'b0);

        // Frame counter wrap from 0xFFFF on the next EOF transfer.
        @(negedge CLK);
        force dut.frame_cnt = 16'hFFFF;
        @(posedge CLK); #1;
        release dut.frame_cnt;
        @(negedge CLK);
        chk("fcnt_preset", FRAME_COUNT, 16'hFFFF);
        send(16'h7005, 1'b0);
        chk_head("wrap_word", 16'h7005, 1'b0, 1'b1, 1'b1);
        @(negedge CLK);
        chk("fcnt_wrap", FRAME_COUNT, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
